// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared widths, limits and the int8 saturation helper for the CNN datapath
package cnn_pkg;

  localparam int DATA_W       = 8;
  localparam int BIAS_W       = 16;
  localparam int ACC_W        = 20;
  localparam int PROD_W       = 2 * DATA_W;
  localparam int ROW_W        = PROD_W + 2;
  localparam int NTAPS        = 9;
  localparam int CONV_LATENCY = 4;
  localparam int INT8_MAX     = 127;
  localparam int INT8_MIN     = -128;

  function automatic logic signed [DATA_W-1:0] sat_int8(input logic signed [ACC_W:0] v);
    if (v > INT8_MAX)
      return DATA_W'(INT8_MAX);
    else if (v < INT8_MIN)
      return DATA_W'(INT8_MIN);
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/conv3x3_mac_relu_if.sv
// rtl/conv3x3_mac_relu_if.sv - weight-load, window and result signals of the 3x3 convolution stage
interface conv3x3_mac_relu_if;
  import cnn_pkg::*;

  logic                     w_load;
  logic signed [DATA_W-1:0] w_data;
  logic signed [BIAS_W-1:0] bias_in;
  logic [3:0]               shift;
  logic                     relu_en;
  logic                     weights_ready;
  logic                     valid_in;
  logic signed [DATA_W-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic                     valid_out;
  logic signed [DATA_W-1:0] data_out;

  modport master (
    output w_load, w_data, bias_in, shift, relu_en, valid_in,
    output win0, win1, win2, win3, win4, win5, win6, win7, win8,
    input  weights_ready, valid_out, data_out
  );

  modport slave (
    input  w_load, w_data, bias_in, shift, relu_en, valid_in,
    input  win0, win1, win2, win3, win4, win5, win6, win7, win8,
    output weights_ready, valid_out, data_out
  );

endinterface

// File: rtl/requant_relu_sat.sv
// rtl/requant_relu_sat.sv - round-half-up right shift, optional ReLU and int8 saturation, registered
module requant_relu_sat
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic signed [ACC_W-1:0]  acc,
  input  logic [3:0]               shift,
  input  logic                     relu_en,
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] data_out
);

  logic [ACC_W:0]           pow2;
  logic signed [ACC_W:0]    wide;
  logic signed [ACC_W:0]    shifted;
  logic signed [ACC_W:0]    relu_val;
  logic signed [DATA_W-1:0] sat_val;

  // One extra bit of headroom so adding the rounding constant can never wrap.
  always_comb begin
    pow2 = {{ACC_W{1'b0}}, 1'b1} << shift;
    wide = {acc[ACC_W-1], acc};
    if (shift != 4'd0)
      wide = wide + $signed(pow2 >> 1);
    shifted  = wide >>> shift;
    relu_val = (relu_en && shifted < 0) ? '0 : shifted;
    sat_val  = sat_int8(relu_val);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in)
        data_out <= sat_val;
    end
  end

endmodule

// File: rtl/conv3x3_mac_relu.sv
// rtl/conv3x3_mac_relu.sv - 3x3 signed convolution: serial weight load, 4-stage MAC pipeline, requantise
module conv3x3_mac_relu
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  conv3x3_mac_relu_if.slave bus
);

  logic signed [DATA_W-1:0] weight [NTAPS];
  logic signed [BIAS_W-1:0] bias;
  logic [3:0]               w_idx;
  logic                     weights_ready;
  logic signed [DATA_W-1:0] win [NTAPS];
  logic                     accept;

  assign win[0] = bus.win0;
  assign win[1] = bus.win1;
  assign win[2] = bus.win2;
  assign win[3] = bus.win3;
  assign win[4] = bus.win4;
  assign win[5] = bus.win5;
  assign win[6] = bus.win6;
  assign win[7] = bus.win7;
  assign win[8] = bus.win8;

  assign bus.weights_ready = weights_ready;
  assign accept            = bus.valid_in && weights_ready;

  // A beat at index 0 with a full set loaded begins a reload and withdraws ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) weight[i] <= '0;
      bias          <= '0;
      w_idx         <= '0;
      weights_ready <= 1'b0;
    end else if (bus.w_load) begin
      weight[w_idx] <= bus.w_data;
      if (w_idx == 4'(NTAPS - 1)) begin
        bias          <= bus.bias_in;
        w_idx         <= '0;
        weights_ready <= 1'b1;
      end else begin
        w_idx <= w_idx + 4'd1;
        if (w_idx == 4'd0)
          weights_ready <= 1'b0;
      end
    end
  end

  logic                     s1_valid, s2_valid, s3_valid;
  logic signed [PROD_W-1:0] s1_prod [NTAPS];
  logic signed [ROW_W-1:0]  s2_row  [3];
  logic signed [ACC_W-1:0]  s3_acc;
  logic signed [BIAS_W-1:0] s1_bias, s2_bias;
  logic [3:0]               s1_shift, s2_shift, s3_shift;
  logic                     s1_relu, s2_relu, s3_relu;

  // Bias and requant controls ride with each window so a later reload cannot touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      for (int i = 0; i < NTAPS; i++) s1_prod[i] <= '0;
      for (int r = 0; r < 3; r++) s2_row[r] <= '0;
      s3_acc   <= '0;
      s1_bias  <= '0;
      s2_bias  <= '0;
      s1_shift <= '0;
      s2_shift <= '0;
      s3_shift <= '0;
      s1_relu  <= 1'b0;
      s2_relu  <= 1'b0;
      s3_relu  <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      if (accept) begin
        for (int i = 0; i < NTAPS; i++)
          s1_prod[i] <= PROD_W'(win[i]) * PROD_W'(weight[i]);
        s1_bias  <= bias;
        s1_shift <= bus.shift;
        s1_relu  <= bus.relu_en;
      end
      if (s1_valid) begin
        for (int r = 0; r < 3; r++)
          s2_row[r] <= ROW_W'(s1_prod[3*r]) + ROW_W'(s1_prod[3*r+1]) + ROW_W'(s1_prod[3*r+2]);
        s2_bias  <= s1_bias;
        s2_shift <= s1_shift;
        s2_relu  <= s1_relu;
      end
      if (s2_valid) begin
        s3_acc   <= ACC_W'(s2_row[0]) + ACC_W'(s2_row[1]) + ACC_W'(s2_row[2]) + ACC_W'(s2_bias);
        s3_shift <= s2_shift;
        s3_relu  <= s2_relu;
      end
    end
  end

  requant_relu_sat u_requant (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (s3_valid),
    .acc       (s3_acc),
    .shift     (s3_shift),
    .relu_en   (s3_relu),
    .valid_out (bus.valid_out),
    .data_out  (bus.data_out)
  );

endmodule

// File: tb/tb_conv3x3_mac_relu.sv
// tb/tb_conv3x3_mac_relu.sv - directed vectors for conv3x3_mac_relu with hand-computed results
module tb_conv3x3_mac_relu;
  import cnn_pkg::*;

  logic clk;
  logic rst_n;
  int   total, bad, cyc;
  int   tap [9];
  int   wt  [9];
  int   out_q   [$];
  int   out_cyc [$];
  int   acc_cyc;

  conv3x3_mac_relu_if bus ();

  conv3x3_mac_relu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_out) begin
      out_q.push_back(bus.data_out);
      out_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_taps();
    bus.win0 = 8'(tap[0]); bus.win1 = 8'(tap[1]); bus.win2 = 8'(tap[2]);
    bus.win3 = 8'(tap[3]); bus.win4 = 8'(tap[4]); bus.win5 = 8'(tap[5]);
    bus.win6 = 8'(tap[6]); bus.win7 = 8'(tap[7]); bus.win8 = 8'(tap[8]);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 9; i++) tap[i] = v;
  endtask

  task automatic set_wt(input int v);
    for (int i = 0; i < 9; i++) wt[i] = v;
  endtask

  task automatic load_weights(input int b);
    for (int i = 0; i < 9; i++) begin
      bus.w_load  = 1'b1;
      bus.w_data  = 8'(wt[i]);
      bus.bias_in = 16'(b);
      step();
    end
    bus.w_load = 1'b0;
  endtask

  // Latency: the result appears on the 4th edge, counting the accepting edge as the 1st.
  task automatic run_win(input string tag, input int sh, input bit relu, input int exp);
    out_q.delete();
    out_cyc.delete();
    apply_taps();
    bus.shift    = 4'(sh);
    bus.relu_en  = relu;
    bus.valid_in = 1'b1;
    step();
    acc_cyc      = cyc;
    bus.valid_in = 1'b0;
    repeat (6) step();
    chk({tag, "_count"}, out_q.size(), 1);
    if (out_q.size() >= 1) begin
      chk({tag, "_lat"}, out_cyc[0] - acc_cyc, CONV_LATENCY - 1);
      chk(tag, out_q[0], exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus.w_load = 1'b0; bus.w_data = '0; bus.bias_in = '0;
    bus.shift = '0; bus.relu_en = 1'b0; bus.valid_in = 1'b0;
    fill(0);
    apply_taps();
    repeat (2) step();
    chk("rst_ready", bus.weights_ready, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data", bus.data_out, 0);
    rst_n = 1'b1;
    step();

    set_wt(1);
    load_weights(0);
    chk("ready_after_load", bus.weights_ready, 1);
    fill(10);
    run_win("sum90", 0, 0, 90);

    set_wt(127);
    load_weights(0);
    fill(127);
    run_win("sat_pos", 0, 0, 127);
    fill(-128);
    run_win("sat_neg", 0, 0, -128);
    run_win("relu_neg", 0, 1, 0);

    set_wt(0);
    wt[4] = 1;
    load_weights(0);
    fill(0);
    tap[4] = 5;
    run_win("round_p5", 1, 0, 3);
    tap[4] = -5;
    run_win("round_m5", 1, 0, -2);
    load_weights(-300);
    tap[4] = 0;
    run_win("bias_sat", 0, 0, -128);
    load_weights(1000);
    tap[4] = 16;
    run_win("round_sh4", 4, 0, 64);

    load_weights(0);
    out_q.delete();
    out_cyc.delete();
    bus.shift   = 4'd0;
    bus.relu_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tap[4] = -40 + 5 * i;
      apply_taps();
      bus.valid_in = 1'b1;
      step();
      if (i == 0) acc_cyc = cyc;
    end
    bus.valid_in = 1'b0;
    repeat (8) step();
    chk("stream_count", out_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < out_q.size()) begin
        chk($sformatf("stream_val%0d", i), out_q[i], -40 + 5 * i);
        chk($sformatf("stream_cyc%0d", i), out_cyc[i] - acc_cyc, CONV_LATENCY - 1 + i);
      end
    end

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    out_q.delete();
    fill(0);
    tap[4] = 50;
    apply_taps();
    bus.valid_in = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      bus.w_load  = 1'b1;
      bus.w_data  = 8'(wt[i]);
      bus.bias_in = '0;
      step();
    end
    bus.w_load   = 1'b0;
    bus.valid_in = 1'b0;
    repeat (6) step();
    chk("gate_none", out_q.size(), 0);
    chk("gate_ready", bus.weights_ready, 1);

    set_wt(0);
    wt[0] = 2;
    wt[4] = 3;
    fill(0);
    tap[0] = 10;
    tap[4] = 20;
    apply_taps();
    out_q.delete();
    out_cyc.delete();
    for (int i = 0; i < 9; i++) begin
      bus.w_load   = 1'b1;
      bus.w_data   = 8'(wt[i]);
      bus.bias_in  = 16'd5;
      bus.valid_in = 1'b1;
      step();
      if (i == 0) begin
        acc_cyc = cyc;
        chk("reload_drop_ready", bus.weights_ready, 0);
      end
      if (i == 5) chk("reload_mid_ready", bus.weights_ready, 0);
    end
    bus.w_load   = 1'b0;
    bus.valid_in = 1'b0;
    chk("reload_ready", bus.weights_ready, 1);
    repeat (4) step();
    chk("reload_count", out_q.size(), 1);
    if (out_q.size() >= 1) begin
      chk("reload_old_w", out_q[0], 20);
      chk("reload_lat", out_cyc[0] - acc_cyc, CONV_LATENCY - 1);
    end
    run_win("new_w", 0, 0, 85);

    fill(1);
    apply_taps();
    bus.valid_in = 1'b1;
    repeat (3) step();
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    chk("midrst_valid", bus.valid_out, 0);
    chk("midrst_ready", bus.weights_ready, 0);
    chk("midrst_data", bus.data_out, 0);
    step();
    step();
    rst_n = 1'b1;
    out_q.delete();
    bus.valid_in = 1'b1;
    repeat (6) step();
    bus.valid_in = 1'b0;
    repeat (6) step();
    chk("postrst_none", out_q.size(), 0);
    chk("postrst_ready", bus.weights_ready, 0);
    load_weights(5);
    run_win("postrst_run", 0, 0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
